prio_arb_sched: RTL and testbench

PRIO_ARB_SCHED -- requirements
Module: prio_arb_sched

---
 rtl/prio_arb_sched.sv | 146 ++++++++++++++
 tb/tb_prio_arb_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_arb_sched.sv
// prio_arb_sched: grants one of WIDTH requesters access to a shared resource
// (IDLE -> OFFER -> BUSY). The grant appears one cycle after a request is seen in IDLE.
// Backpressure: the offer holds until res_ready. BUSY ends on res_done, or on a
// forced release after TIMEOUT cycles.
// Optional macro PRIO_ARB_SCHED_RR_EN: round-robin arbitration. When the macro is
// undefined, the arbiter uses fixed MSB-first priority.
// Ports:
//   clk, rst (async active-high)     clock and reset
//   req[WIDTH]                       request levels
//   gnt[WIDTH], gnt_id, gnt_valid    registered grant and offer
//   res_ready, res_done              resource accept / completion
//   busy, timeout                    transaction in progress / forced-release pulse
module prio_arb_sched #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_id,
    output logic                     gnt_valid,
    input  logic                     res_ready,
    input  logic                     res_done,
    output logic                     busy,
    output logic                     timeout
);

    localparam int          IDW     = $clog2(WIDTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_gnt;
    logic [IDW-1:0]   r_gnt_id;
    logic             r_gnt_valid;
    logic             r_busy;
    logic             r_timeout;
    logic [15:0]      r_cnt;

    logic [WIDTH-1:0] w_cand;
    logic [IDW-1:0]   w_win;
    logic [WIDTH-1:0] w_onehot;

`ifdef PRIO_ARB_SCHED_RR_EN
    // r_ptr holds the id of the last transaction that entered BUSY. Only indices
    // strictly below r_ptr are preferred. If none of them request, every index
    // competes again, which wraps the rotation back to the MSB.
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] w_low;
    assign w_low = req & ~({WIDTH{1'b1}} << r_ptr);
`endif

    always_comb begin
        w_cand = req;
`ifdef PRIO_ARB_SCHED_RR_EN
        if (w_low != '0) begin
            w_cand = w_low;
        end
`endif
        // Ascending scan: the highest set index is written last and wins.
        w_win = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_cand[i]) begin
                w_win = IDW'(i);
            end
        end
        w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << w_win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
`ifdef PRIO_ARB_SCHED_RR_EN
            r_ptr       <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != '0) begin
                        r_gnt       <= w_onehot;
                        r_gnt_id    <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // If acceptance and withdrawal occur on the same edge, acceptance wins.
                    if (res_ready) begin
                        r_gnt_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY;
`ifdef PRIO_ARB_SCHED_RR_EN
                        r_ptr       <= r_gnt_id;
`endif
                    end else if ((req & r_gnt) == '0) begin
                        r_gnt       <= '0;
                        r_gnt_id    <= '0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (res_done) begin
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == TO_LAST) begin
                        // This is the TIMEOUT-th BUSY cycle without completion.
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_prio_arb_sched.sv
// tb_prio_arb_sched: directed scenarios plus randomized traffic for prio_arb_sched,
// compared every cycle against a transaction-level reference model.
// DUT built with WIDTH=8, TIMEOUT=4.
module tb_prio_arb_sched;

    localparam int W  = 8;
    localparam int TO = 4;
`ifdef PRIO_ARB_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] req = '0;
    logic [W-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         gnt_valid;
    logic         res_ready = 1'b0;
    logic         res_done  = 1'b0;
    logic         busy;
    logic         timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the current phase, the owner of the grant, the number of
    // BUSY cycles elapsed, the rotation point, and the pending timeout pulse.
    typedef enum int {PH_IDLE, PH_OFFER, PH_BUSY} phase_t;
    phase_t m_ph    = PH_IDLE;
    int     m_owner = 0;
    int     m_elap  = 0;
    int     m_last  = 0;
    bit     m_to    = 1'b0;

    prio_arb_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .res_ready (res_ready),
        .res_done  (res_done),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Choose a winner by walking requesters from the top. With round-robin
    // enabled, first search only the requesters below the last BUSY owner.
    function automatic int choose(input logic [W-1:0] r);
        if (RR) begin
            for (int i = m_last - 1; i >= 0; i--) if (r[i]) return i;
        end
        for (int i = W - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_owner = 0; m_elap = 0; m_last = 0; m_to = 1'b0;
    endtask

    task automatic model_edge();
        m_to = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            case (m_ph)
                PH_IDLE: if (req != 0) begin
                    m_owner = choose(req);
                    m_ph = PH_OFFER;
                end
                PH_OFFER: if (res_ready) begin
                    m_ph = PH_BUSY; m_elap = 0; m_last = m_owner;
                end else if (!req[m_owner]) begin
                    m_ph = PH_IDLE; m_owner = 0;
                end
                PH_BUSY: begin
                    m_elap++;
                    if (res_done) begin
                        m_ph = PH_IDLE; m_owner = 0;
                    end else if (m_elap == TO) begin
                        m_ph = PH_IDLE; m_owner = 0; m_to = 1'b1;
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] eg;
        eg = (m_ph == PH_IDLE) ? '0 : (W'(1) << m_owner);
        chk({tag, ".gnt"},       32'(gnt),       32'(eg));
        chk({tag, ".gnt_id"},    32'(gnt_id),    (m_ph == PH_IDLE) ? 32'd0 : 32'(m_owner));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_ph == PH_OFFER));
        chk({tag, ".busy"},      32'(busy),      32'(m_ph == PH_BUSY));
        chk({tag, ".timeout"},   32'(timeout),   32'(m_to));
    endtask

    // One clock: the model follows the sampled inputs, and the DUT is read 1ns after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Async reset: the outputs must clear before any clock edge arrives.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        step({tag, ".hold"});
        rst = 1'b0;
    endtask

    initial begin
        #2;
        pulse_reset("reset");

        // MSB priority and one-cycle grant latency.
        req = 8'h12;
        step("lat");
        chk("lat.gnt_const", 32'(gnt), 32'h10);
        chk("lat.id_const",  32'(gnt_id), 32'd4);
        chk("lat.vld_const", 32'(gnt_valid), 32'd1);

        // Offer holds while res_ready is low, then accept and complete.
        for (int i = 0; i < 5; i++) begin
            step("hold");
            chk("hold.gnt_const", 32'(gnt), 32'h10);
        end
        res_ready = 1'b1;
        step("accept");
        chk("accept.busy_const", 32'(busy), 32'd1);
        chk("accept.vld_const",  32'(gnt_valid), 32'd0);
        res_ready = 1'b0; res_done = 1'b1;
        step("done");
        chk("done.gnt_const", 32'(gnt), 32'h0);
        res_done = 1'b0;

        // Forced release after TO BUSY cycles without res_done.
        step("to.offer");
        res_ready = 1'b1;
        step("to.accept");
        res_ready = 1'b0; req = '0;
        for (int i = 0; i < TO - 1; i++) begin
            step("to.wait");
            chk("to.no_pulse", 32'(timeout), 32'd0);
        end
        step("to.fire");
        chk("to.pulse_const", 32'(timeout), 32'd1);
        chk("to.busy_const",  32'(busy), 32'd0);
        step("to.after");
        chk("to.pulse_end", 32'(timeout), 32'd0);

        // Arbitration sequence with every request held high.
        pulse_reset("rr.reset");
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step("seq.offer");
            chk("seq.id_const", 32'(gnt_id), RR ? 32'(7 - (k % 8)) : 32'd7);
            res_ready = 1'b1;
            step("seq.accept");
            res_ready = 1'b0; res_done = 1'b1;
            step("seq.done");
            res_done = 1'b0;
        end

        // Reset in the middle of a BUSY transaction owned by requester 3.
        pulse_reset("mid.pre");
        req = 8'h08;
        step("mid.offer");
        res_ready = 1'b1;
        step("mid.accept");
        chk("mid.id3", 32'(gnt_id), 32'd3);
        res_ready = 1'b0;
        #2;
        pulse_reset("mid.rst");
        chk("mid.gnt_zero", 32'(gnt), 32'h0);
        req = 8'h09;
        step("mid.regrant");
        chk("mid.id_const", 32'(gnt_id), 32'd3);

        // Random traffic, including request drops, idle strobes, and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = W'($urandom);
            else if ($urandom_range(0, 7) == 0) req = '0;
            res_ready = ($urandom_range(0, 2) == 0);
            res_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rnd.rst");
            end else begin
                step("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
